// File: rtl/arbitrated_block_memory.sv
// N-port block-granular main-memory model; a round-robin arbiter serialises
// every request through a single fixed-latency access engine.
module arbitrated_block_memory #(
  parameter int NUM_PORTS    = 2,
  parameter int ADDR_W       = 16,
  parameter int WORD_W       = 8,
  parameter int BLOCK_WORDS  = 4,
  parameter int MEM_WORDS    = 1024,
  parameter int ACCESS_DELAY = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_PORTS-1:0]                  req,
  input  logic [NUM_PORTS-1:0]                  rdwt,
  input  logic [NUM_PORTS*ADDR_W-1:0]           addr,
  input  logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0] wdata,
  output logic [NUM_PORTS*BLOCK_WORDS*WORD_W-1:0] rdata,
  output logic [NUM_PORTS-1:0]                  done,
  output logic [NUM_PORTS-1:0]                  addr_err,
  output logic                                  busy
);

  localparam int BLK_W  = BLOCK_WORDS * WORD_W;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W  = $clog2(ACCESS_DELAY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                     r_state;
  logic [PTR_W-1:0]           r_ptr;
  logic [PTR_W-1:0]           r_gnt;
  logic                       r_rdwt;
  logic [ADDR_W-1:0]          r_addr;
  logic [BLK_W-1:0]           r_wdata;
  logic [CNT_W-1:0]           r_cnt;
  logic [NUM_PORTS*BLK_W-1:0] r_rdata;
  logic [NUM_PORTS-1:0]       r_done;
  logic [NUM_PORTS-1:0]       r_addr_err;
  logic                       r_busy;
  logic [WORD_W-1:0]          r_mem [MEM_WORDS];

  logic [NUM_PORTS-1:0]       w_rot;
  int unsigned                w_sel;
  logic                       w_any;
  logic [PTR_W-1:0]           w_gnt;
  logic [PTR_W-1:0]           w_ptr_nxt;
  logic                       w_sel_rdwt;
  logic [ADDR_W-1:0]          w_sel_addr;
  logic [BLK_W-1:0]           w_sel_wdata;
  logic                       w_in_range;
  logic [MEM_AW-1:0]          w_base;
  logic [BLK_W-1:0]           w_rblock;
  logic                       w_commit;
  logic                       w_mem_wr;

  // Rotate requests so bit 0 is the current highest-priority port, then take the first set bit.
  always_comb begin
    w_rot = NUM_PORTS'({req, req} >> r_ptr);
    w_any = 1'b0;
    w_sel = 0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (!w_any && w_rot[j]) begin
        w_any = 1'b1;
        w_sel = j;
      end
    end
    w_gnt     = PTR_W'((32'(r_ptr) + w_sel) % 32'(NUM_PORTS));
    w_ptr_nxt = PTR_W'((32'(r_ptr) + w_sel + 1) % 32'(NUM_PORTS));
  end

  always_comb begin
    w_sel_rdwt  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (PTR_W'(p) == w_gnt) begin
        w_sel_rdwt  = rdwt[p];
        w_sel_addr  = addr[p*ADDR_W +: ADDR_W];
        w_sel_wdata = wdata[p*BLK_W +: BLK_W];
      end
    end
  end

  assign w_in_range = (32'(r_addr) < 32'(MEM_WORDS));
  assign w_base     = MEM_AW'(r_addr) & ~MEM_AW'(BLOCK_WORDS - 1);
  assign w_commit   = (r_state == S_WAIT) && (r_cnt == CNT_W'(1));
  assign w_mem_wr   = rst_n && w_commit && r_rdwt && w_in_range;

  always_comb begin
    w_rblock = '0;
    for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
      w_rblock[k*WORD_W +: WORD_W] = r_mem[w_base | MEM_AW'(k)];
    end
  end

  // Array contents survive reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      for (int unsigned k = 0; k < BLOCK_WORDS; k++) begin
        r_mem[w_base | MEM_AW'(k)] <= r_wdata[k*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_rdwt     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_done     <= '0;
      r_addr_err <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_done     <= '0;
      r_addr_err <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_gnt;
            r_ptr   <= w_ptr_nxt;
            r_rdwt  <= w_sel_rdwt;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_cnt   <= CNT_W'(ACCESS_DELAY);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (PTR_W'(p) == r_gnt) begin
                r_done[p]     <= 1'b1;
                r_addr_err[p] <= !w_in_range;
                if (w_in_range && !r_rdwt) begin
                  r_rdata[p*BLK_W +: BLK_W] <= w_rblock;
                end
              end
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata    = r_rdata;
  assign done     = r_done;
  assign addr_err = r_addr_err;
  assign busy     = r_busy;

endmodule

// File: tb/tb_arbitrated_block_memory.sv
// Bench for arbitrated_block_memory: directed scenarios plus randomized request
// rounds checked against a transaction-level memory/arbiter model.
module tb_arbitrated_block_memory;

  localparam int NP  = 2;
  localparam int AW  = 16;
  localparam int WW  = 8;
  localparam int BW  = 4;
  localparam int MW  = 1024;
  localparam int D   = 4;
  localparam int BLK = BW * WW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP-1:0]     req, rdwt, done, addr_err;
  logic [NP*AW-1:0]  addr;
  logic [NP*BLK-1:0] wdata, rdata;
  logic              busy;

  logic [NP-1:0]     s_req [2];
  logic [NP-1:0]     s_rdwt [2];
  logic [NP-1:0]     s_done [2];
  logic [NP-1:0]     s_err [2];
  logic [NP*AW-1:0]  s_addr [2];
  logic [NP*BLK-1:0] s_wdata [2];
  logic [NP*BLK-1:0] s_rdata [2];
  logic              s_busy [2];

  always #5 clk = ~clk;

  arbitrated_block_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW),
                            .MEM_WORDS(MW), .ACCESS_DELAY(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rdwt(rdwt), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .addr_err(addr_err), .busy(busy));

  arbitrated_block_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW),
                            .MEM_WORDS(MW), .ACCESS_DELAY(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .req(s_req[0]), .rdwt(s_rdwt[0]), .addr(s_addr[0]),
    .wdata(s_wdata[0]), .rdata(s_rdata[0]), .done(s_done[0]), .addr_err(s_err[0]),
    .busy(s_busy[0]));

  arbitrated_block_memory #(.NUM_PORTS(NP), .ADDR_W(AW), .WORD_W(WW), .BLOCK_WORDS(BW),
                            .MEM_WORDS(MW), .ACCESS_DELAY(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .req(s_req[1]), .rdwt(s_rdwt[1]), .addr(s_addr[1]),
    .wdata(s_wdata[1]), .rdata(s_rdata[1]), .done(s_done[1]), .addr_err(s_err[1]),
    .busy(s_busy[1]));

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state.
  logic [WW-1:0]  m_mem [MW];
  logic [BLK-1:0] m_rdata [NP];
  int unsigned    m_ptr;

  // Per-round stimulus.
  logic [NP-1:0]  t_mask, t_rdwt, t_drop;
  logic [AW-1:0]  t_addr [NP];
  logic [BLK-1:0] t_data [NP];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BLK-1:0] m_blk(input int unsigned a);
    logic [BLK-1:0] v;
    int unsigned b;
    b = (a / BW) * BW;
    for (int unsigned k = 0; k < BW; k++) v[k*WW +: WW] = m_mem[b + k];
    return v;
  endfunction

  function automatic logic [NP*BLK-1:0] m_rvec();
    logic [NP*BLK-1:0] v;
    for (int unsigned p = 0; p < NP; p++) v[p*BLK +: BLK] = m_rdata[p];
    return v;
  endfunction

  task automatic clear_ops();
    t_mask = '0;
    t_rdwt = '0;
    t_drop = '0;
  endtask

  task automatic set_op(input int unsigned p, input logic wr, input logic [AW-1:0] a,
                        input logic [BLK-1:0] d);
    t_mask[p] = 1'b1;
    t_rdwt[p] = wr;
    t_addr[p] = a;
    t_data[p] = d;
  endtask

  // All masked ports request together while the DUT is idle; the model predicts
  // round-robin order and a grant every D+2 cycles, done D edges after each grant.
  task automatic run_round();
    int unsigned order[$];
    int unsigned m, n_total, g, q;
    logic [NP-1:0] exp_done, exp_err;
    logic exp_busy;
    order = {};
    for (int unsigned i = 0; i < NP; i++) begin
      q = (m_ptr + i) % NP;
      if (t_mask[q]) order.push_back(q);
    end
    m = order.size();
    if (m == 0) return;
    for (int unsigned i = 0; i < NP; i++) begin
      req[i]              = t_mask[i];
      rdwt[i]             = t_rdwt[i];
      addr[i*AW +: AW]    = t_addr[i];
      wdata[i*BLK +: BLK] = t_data[i];
    end
    n_total = m * (D + 2);
    for (int unsigned n = 1; n <= n_total; n++) begin
      @(posedge clk); #1;
      exp_done = '0;
      exp_err  = '0;
      exp_busy = 1'b0;
      for (int unsigned k = 0; k < m; k++) begin
        g = 1 + k * (D + 2);
        q = order[k];
        if (n >= g && n <= g + D) exp_busy = 1'b1;
        if (n == g + D) begin
          exp_done[q] = 1'b1;
          if (32'(t_addr[q]) >= MW) exp_err[q] = 1'b1;
          else if (t_rdwt[q]) begin
            for (int unsigned w = 0; w < BW; w++)
              m_mem[(t_addr[q] / BW) * BW + w] = t_data[q][w*WW +: WW];
          end else m_rdata[q] = m_blk(t_addr[q]);
          m_ptr = (q + 1) % NP;
        end
      end
      check("done", 64'(done), 64'(exp_done));
      check("addr_err", 64'(addr_err), 64'(exp_err));
      check("busy", 64'(busy), 64'(exp_busy));
      if (exp_done != '0) check("rdata", 64'(rdata), 64'(m_rvec()));
      for (int unsigned k = 0; k < m; k++) begin
        g = 1 + k * (D + 2);
        q = order[k];
        if (n == g && t_drop[q]) begin
          req[q]              = 1'b0;
          rdwt[q]             = ~rdwt[q];
          addr[q*AW +: AW]    = AW'($urandom);
          wdata[q*BLK +: BLK] = BLK'($urandom);
        end
        if (n == g + D) req[q] = 1'b0;
      end
    end
  endtask

  // Port 0 of a sweep instance; req dropped right after the grant edge.
  task automatic sweep_access(input int unsigned w, input int unsigned dly, input logic wr,
                              input logic [AW-1:0] a, input logic [BLK-1:0] d,
                              input logic [BLK-1:0] exp_rd);
    int unsigned lat;
    lat = 0;
    s_req[w]           = 2'b01;
    s_rdwt[w]          = {1'b0, wr};
    s_addr[w][AW-1:0]  = a;
    s_wdata[w][BLK-1:0] = d;
    for (int unsigned n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (s_done[w][0]) lat = n - 1;
      if (n == 1) begin
        s_req[w]           = '0;
        s_addr[w][AW-1:0]  = '1;
        s_wdata[w][BLK-1:0] = '0;
      end
    end
    check("sweep_latency", 64'(lat), 64'(dly));
    if (!wr) check("sweep_rdata", 64'(s_rdata[w][BLK-1:0]), 64'(exp_rd));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; rdwt = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2; i++) begin
      s_req[i] = '0; s_rdwt[i] = '0; s_addr[i] = '0; s_wdata[i] = '0;
    end
    for (int unsigned p = 0; p < NP; p++) begin
      m_rdata[p] = '0; t_addr[p] = '0; t_data[p] = '0;
    end
    clear_ops();
    m_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(addr_err), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    rst_n = 1'b1;

    // Simultaneous writes: port 0 first after reset.
    clear_ops();
    set_op(0, 1'b1, 16'h0010, 32'hDDCCBBAA);
    set_op(1, 1'b1, 16'h0020, 32'h11223344);
    run_round();
    clear_ops();
    set_op(0, 1'b0, 16'h0013, '0);
    run_round();
    check("rd_0013", 64'(rdata[31:0]), 64'(32'hDDCCBBAA));
    // Pointer now favours port 1.
    clear_ops();
    set_op(0, 1'b0, 16'h0020, '0);
    set_op(1, 1'b1, 16'h0030, 32'h0);
    run_round();
    check("rd_0020", 64'(rdata[31:0]), 64'(32'h11223344));
    check("rdata1_kept", 64'(rdata[63:32]), 64'(0));
    clear_ops();
    set_op(0, 1'b0, 16'h0400, '0);
    run_round();
    check("oor_keeps", 64'(rdata[31:0]), 64'(32'h11223344));

    // Reset in the middle of a write.
    req[0] = 1'b1; rdwt[0] = 1'b1; addr[AW-1:0] = 16'h0030; wdata[BLK-1:0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0;
    @(posedge clk); #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rdata", 64'(rdata), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    rst_n = 1'b1;
    for (int unsigned p = 0; p < NP; p++) m_rdata[p] = '0;
    m_ptr = 0;
    for (int unsigned c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 64'(done), 64'(0));
    end
    clear_ops();
    set_op(0, 1'b0, 16'h0030, '0);
    run_round();
    check("rd_0030", 64'(rdata[31:0]), 64'(0));

    sweep_access(0, 1, 1'b1, 16'h0040, 32'h5AC30F96, '0);
    sweep_access(0, 1, 1'b0, 16'h0042, '0, 32'h5AC30F96);
    sweep_access(1, 8, 1'b1, 16'h0041, 32'h87654321, '0);
    sweep_access(1, 8, 1'b0, 16'h0043, '0, 32'h87654321);

    // Known contents for the random region.
    for (int unsigned b = 0; b < 16; b++) begin
      clear_ops();
      set_op(0, 1'b1, AW'(b * BW), '0);
      run_round();
    end

    for (int unsigned r = 0; r < 60; r++) begin
      clear_ops();
      for (int unsigned p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 5) == 0) set_op(p, 1'($urandom), AW'($urandom_range(MW, 65535)), BLK'($urandom));
          else set_op(p, 1'($urandom), AW'($urandom_range(0, 63)), BLK'($urandom));
          t_drop[p] = 1'($urandom);
        end
      end
      run_round();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
